// File: rtl/slap_video_defs.sv
// rtl/slap_video_defs.sv - shared video constants and stage-1 pixel record
package slap_video_defs;

  localparam int PIX_W     = 8;
  localparam int COL_W     = 4;
  localparam int PAL_DEPTH = 256;
  localparam int PAL_AW    = 8;

  localparam int LE_FG = 0;
  localparam int LE_BG = 1;
  localparam int LE_SP = 2;

  // Blanking is carried as "active" flags so every register clears to 0
  // while the outputs still read as blanked out of reset.
  typedef struct packed {
    logic [PIX_W-1:0] fg;
    logic [PIX_W-1:0] sp;
    logic [PIX_W-1:0] bg;
    logic             fg_op;
    logic             sp_op;
    logic             bg_op;
    logic             hact;
    logic             vact;
  } s1_t;

endpackage

// File: rtl/slap_palette_prom.sv
// rtl/slap_palette_prom.sv - 256x4 palette RAM, download write port and video read port
module slap_palette_prom
  import slap_video_defs::*;
(
  input  logic              master_clk,
  input  logic              wr_en,
  input  logic [PAL_AW-1:0] wr_addr,
  input  logic [COL_W-1:0]  wr_data,
  input  logic [PAL_AW-1:0] rd_addr,
  output logic [COL_W-1:0]  rd_data
);

  logic [COL_W-1:0] mem [0:PAL_DEPTH-1];

  // Same-address read and write in one cycle returns the old word.
  always_ff @(posedge master_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/slap_colour_mixer.sv
// rtl/slap_colour_mixer.sv - layer priority, palette lookup and blanking for the final pixel stage
module slap_colour_mixer
  import slap_video_defs::*;
(
  input  logic             master_clk,
  input  logic             reset_n,
  input  logic             pixel_ce,
  input  logic [PIX_W-1:0] fg_pixel,
  input  logic [PIX_W-1:0] bg_pixel,
  input  logic [PIX_W-1:0] sp_pixel,
  input  logic [2:0]       layer_en,
  input  logic             hblank_in,
  input  logic             vblank_in,
  input  logic [24:0]      dn_addr,
  input  logic [7:0]       dn_data,
  input  logic             dn_wr,
  input  logic             prom_r_cs,
  input  logic             prom_g_cs,
  input  logic             prom_b_cs,
  output logic [COL_W-1:0] red,
  output logic [COL_W-1:0] green,
  output logic [COL_W-1:0] blue,
  output logic             hblank_out,
  output logic             vblank_out
);

  s1_t              s1;
  logic [PAL_AW-1:0] idx_sel;
  logic [PAL_AW-1:0] idx_s2;
  logic             hact_s2;
  logic             vact_s2;
  logic [COL_W-1:0] r_s3;
  logic [COL_W-1:0] g_s3;
  logic [COL_W-1:0] b_s3;
  logic             hact_s3;
  logic             vact_s3;
  logic [COL_W-1:0] pal_r;
  logic [COL_W-1:0] pal_g;
  logic [COL_W-1:0] pal_b;
  logic             blank;
  logic             unused_dn;

  assign unused_dn = ^{dn_addr[24:8], dn_data[7:4]};

  always_comb begin
    idx_sel = '0;
    if (s1.fg_op) begin
      idx_sel = s1.fg;
    end else if (s1.sp_op) begin
      idx_sel = s1.sp;
    end else if (s1.bg_op) begin
      idx_sel = s1.bg;
    end
  end

  // The PROM read issued from idx_s2 completes on the non-enabled cycle
  // in between, so S3 simply captures pal_* on the next pixel tick.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      idx_s2  <= '0;
      hact_s2 <= 1'b0;
      vact_s2 <= 1'b0;
      r_s3    <= '0;
      g_s3    <= '0;
      b_s3    <= '0;
      hact_s3 <= 1'b0;
      vact_s3 <= 1'b0;
    end else if (pixel_ce) begin
      s1.fg    <= fg_pixel;
      s1.sp    <= sp_pixel;
      s1.bg    <= bg_pixel;
      s1.fg_op <= (fg_pixel[1:0] != 2'b00) && layer_en[LE_FG];
      s1.sp_op <= (sp_pixel[3:0] != 4'h0) && layer_en[LE_SP];
      s1.bg_op <= (bg_pixel[3:0] != 4'h0) && layer_en[LE_BG];
      s1.hact  <= ~hblank_in;
      s1.vact  <= ~vblank_in;
      idx_s2   <= idx_sel;
      hact_s2  <= s1.hact;
      vact_s2  <= s1.vact;
      r_s3     <= pal_r;
      g_s3     <= pal_g;
      b_s3     <= pal_b;
      hact_s3  <= hact_s2;
      vact_s3  <= vact_s2;
    end
  end

  slap_palette_prom u_prom_r (
    .master_clk (master_clk),
    .wr_en      (dn_wr & prom_r_cs),
    .wr_addr    (dn_addr[7:0]),
    .wr_data    (dn_data[3:0]),
    .rd_addr    (idx_s2),
    .rd_data    (pal_r)
  );

  slap_palette_prom u_prom_g (
    .master_clk (master_clk),
    .wr_en      (dn_wr & prom_g_cs),
    .wr_addr    (dn_addr[7:0]),
    .wr_data    (dn_data[3:0]),
    .rd_addr    (idx_s2),
    .rd_data    (pal_g)
  );

  slap_palette_prom u_prom_b (
    .master_clk (master_clk),
    .wr_en      (dn_wr & prom_b_cs),
    .wr_addr    (dn_addr[7:0]),
    .wr_data    (dn_data[3:0]),
    .rd_addr    (idx_s2),
    .rd_data    (pal_b)
  );

  assign hblank_out = ~hact_s3;
  assign vblank_out = ~vact_s3;
  assign blank      = hblank_out | vblank_out;
  assign red        = blank ? '0 : r_s3;
  assign green      = blank ? '0 : g_s3;
  assign blue       = blank ? '0 : b_s3;

endmodule

// File: tb/tb_slap_colour_mixer.sv
// tb/tb_slap_colour_mixer.sv - directed-vector bench for slap_colour_mixer
module tb_slap_colour_mixer;

  logic        master_clk = 1'b0;
  logic        reset_n;
  logic        pixel_ce;
  logic [7:0]  fg_pixel;
  logic [7:0]  bg_pixel;
  logic [7:0]  sp_pixel;
  logic [2:0]  layer_en;
  logic        hblank_in;
  logic        vblank_in;
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        prom_r_cs;
  logic        prom_g_cs;
  logic        prom_b_cs;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hblank_out;
  logic        vblank_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 master_clk = ~master_clk;

  slap_colour_mixer dut (
    .master_clk (master_clk),
    .reset_n    (reset_n),
    .pixel_ce   (pixel_ce),
    .fg_pixel   (fg_pixel),
    .bg_pixel   (bg_pixel),
    .sp_pixel   (sp_pixel),
    .layer_en   (layer_en),
    .hblank_in  (hblank_in),
    .vblank_in  (vblank_in),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .dn_wr      (dn_wr),
    .prom_r_cs  (prom_r_cs),
    .prom_g_cs  (prom_g_cs),
    .prom_b_cs  (prom_b_cs),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hblank_out (hblank_out),
    .vblank_out (vblank_out)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [3:0] r, input logic [3:0] g,
                         input logic [3:0] b);
    chk({tag, ".r"}, {4'h0, red}, {4'h0, r});
    chk({tag, ".g"}, {4'h0, green}, {4'h0, g});
    chk({tag, ".b"}, {4'h0, blue}, {4'h0, b});
  endtask

  // One pixel tick: an enabled clock followed by a non-enabled clock.
  task automatic tick();
    pixel_ce = 1'b1;
    @(posedge master_clk);
    #1;
    pixel_ce = 1'b0;
    @(posedge master_clk);
    #1;
  endtask

  task automatic dl(input logic [2:0] cs, input logic [7:0] a, input logic [3:0] d);
    prom_r_cs = cs[0];
    prom_g_cs = cs[1];
    prom_b_cs = cs[2];
    dn_addr   = {17'd0, a};
    dn_data   = {4'h0, d};
    dn_wr     = 1'b1;
    @(posedge master_clk);
    #1;
    dn_wr     = 1'b0;
    prom_r_cs = 1'b0;
    prom_g_cs = 1'b0;
    prom_b_cs = 1'b0;
  endtask

  task automatic pix(input logic [7:0] f, input logic [7:0] s, input logic [7:0] b,
                     input logic [2:0] le);
    fg_pixel = f;
    sp_pixel = s;
    bg_pixel = b;
    layer_en = le;
  endtask

  initial begin
    reset_n   = 1'b0;
    pixel_ce  = 1'b0;
    hblank_in = 1'b0;
    vblank_in = 1'b0;
    dn_addr   = '0;
    dn_data   = '0;
    dn_wr     = 1'b0;
    prom_r_cs = 1'b0;
    prom_g_cs = 1'b0;
    prom_b_cs = 1'b0;
    pix(8'h00, 8'h00, 8'h00, 3'b111);

    #2;
    chk_rgb("reset", 4'h0, 4'h0, 4'h0);
    chk("reset.hb", {7'd0, hblank_out}, 8'h01);
    chk("reset.vb", {7'd0, vblank_out}, 8'h01);
    @(posedge master_clk);
    @(posedge master_clk);
    #1;
    reset_n = 1'b1;

    // Palette load with pixel_ce low; 0x93 exercises a multi-select write.
    dl(3'b111, 8'h2D, 4'h0);
    dl(3'b001, 8'h2D, 4'hA);
    dl(3'b010, 8'h2D, 4'h3);
    dl(3'b100, 8'h2D, 4'hC);
    dl(3'b001, 8'h51, 4'h5);
    dl(3'b010, 8'h51, 4'h1);
    dl(3'b100, 8'h51, 4'hE);
    dl(3'b111, 8'h93, 4'h6);
    dl(3'b001, 8'h93, 4'h9);
    dl(3'b010, 8'h93, 4'h3);
    dl(3'b001, 8'h00, 4'h4);
    dl(3'b010, 8'h00, 4'h8);
    dl(3'b100, 8'h00, 4'h1);
    dl(3'b001, 8'h11, 4'h1);
    dl(3'b010, 8'h11, 4'hD);
    dl(3'b100, 8'h11, 4'h2);
    dl(3'b111, 8'h7F, 4'hF);

    pix(8'h2D, 8'h51, 8'h93, 3'b111);
    tick();
    tick();
    chk("boot.t2.hb", {7'd0, hblank_out}, 8'h01);
    tick();
    chk("boot.t3.hb", {7'd0, hblank_out}, 8'h00);
    chk_rgb("prio.fg", 4'hA, 4'h3, 4'hC);

    pix(8'h2C, 8'h51, 8'h93, 3'b111);
    repeat (3) tick();
    chk_rgb("fg_transp", 4'h5, 4'h1, 4'hE);

    pix(8'h2D, 8'h51, 8'h93, 3'b110);
    repeat (3) tick();
    chk_rgb("fg_disabled", 4'h5, 4'h1, 4'hE);

    pix(8'h2C, 8'h51, 8'h93, 3'b011);
    repeat (3) tick();
    chk_rgb("sp_disabled", 4'h9, 4'h3, 4'h6);

    pix(8'h00, 8'h30, 8'h40, 3'b111);
    repeat (3) tick();
    chk_rgb("backdrop", 4'h4, 4'h8, 4'h1);

    pix(8'h7F, 8'h00, 8'h00, 3'b111);
    repeat (3) tick();
    chk_rgb("white", 4'hF, 4'hF, 4'hF);
    hblank_in = 1'b1;
    tick();
    hblank_in = 1'b0;
    tick();
    chk("hb.t2", {7'd0, hblank_out}, 8'h00);
    tick();
    chk("hb.t3", {7'd0, hblank_out}, 8'h01);
    chk("hb.t3.vb", {7'd0, vblank_out}, 8'h00);
    chk_rgb("hb.t3", 4'h0, 4'h0, 4'h0);
    tick();
    chk("hb.t4", {7'd0, hblank_out}, 8'h00);
    chk_rgb("hb.t4", 4'hF, 4'hF, 4'hF);

    vblank_in = 1'b1;
    repeat (3) tick();
    chk("vb.vb", {7'd0, vblank_out}, 8'h01);
    chk("vb.hb", {7'd0, hblank_out}, 8'h00);
    chk_rgb("vb", 4'h0, 4'h0, 4'h0);
    vblank_in = 1'b0;

    // Overwrite B[0x11] on exactly the clock that the pixel's PROM read happens.
    pix(8'h11, 8'h51, 8'h93, 3'b111);
    tick();
    pixel_ce = 1'b1;
    @(posedge master_clk);
    #1;
    pixel_ce  = 1'b0;
    prom_b_cs = 1'b1;
    dn_addr   = {17'd0, 8'h11};
    dn_data   = 8'h07;
    dn_wr     = 1'b1;
    @(posedge master_clk);
    #1;
    dn_wr     = 1'b0;
    prom_b_cs = 1'b0;
    tick();
    chk_rgb("coll.old", 4'h1, 4'hD, 4'h2);
    tick();
    chk_rgb("coll.new", 4'h1, 4'hD, 4'h7);

    pix(8'h2D, 8'h51, 8'h93, 3'b111);
    repeat (3) tick();
    chk_rgb("pre_rst", 4'hA, 4'h3, 4'hC);
    #2;
    reset_n = 1'b0;
    #1;
    chk_rgb("rst.async", 4'h0, 4'h0, 4'h0);
    chk("rst.async.hb", {7'd0, hblank_out}, 8'h01);
    chk("rst.async.vb", {7'd0, vblank_out}, 8'h01);
    @(posedge master_clk);
    @(posedge master_clk);
    #1;
    reset_n = 1'b1;
    tick();
    chk("rst.t1.hb", {7'd0, hblank_out}, 8'h01);
    tick();
    chk("rst.t2.hb", {7'd0, hblank_out}, 8'h01);
    chk_rgb("rst.t2", 4'h0, 4'h0, 4'h0);
    tick();
    chk("rst.t3.hb", {7'd0, hblank_out}, 8'h00);
    chk_rgb("rst.t3", 4'hA, 4'h3, 4'hC);

    pixel_ce = 1'b0;
    pix(8'h2C, 8'h51, 8'h93, 3'b111);
    hblank_in = 1'b1;
    repeat (6) @(posedge master_clk);
    #1;
    chk_rgb("freeze", 4'hA, 4'h3, 4'hC);
    chk("freeze.hb", {7'd0, hblank_out}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
